mul32: RTL and testbench

Multi-cycle 32×32→64-bit integer multiplier for the execute stage, the counterpart of the iterative divider. It serves RV32M MUL/MULH/MULHSU/MULHU. It uses radix-4 Booth recoding, with one partial product per cycle and no pipelining. It shares the divider's `in_en`/`idle`/`out_en` handshake, so the issue logic drives both units the same way.

---
 rtl/mul32.sv | 87 ++++++++
 tb/tb_mul32.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mul32.sv
// mul32: radix-4 Booth 32x32->64 multiplier (clk, rst, in_en/a/b/a_signed/b_signed in; idle/out_en/p_hi/p_lo out)
module mul32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        a_signed,
  input  logic        b_signed,
  output logic        idle,
  output logic        out_en,
  output logic [31:0] p_hi,
  output logic [31:0] p_lo
);
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
  state_t      state_q, state_d;
  logic [35:0] m_q, m_d, u_q, u_d, dig, sum;
  logic [33:0] l_q, l_d;
  logic        g_q, g_d, out_en_q, out_en_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] p_q, p_d;
  logic [2:0]  t;
  always_comb begin
    t = {l_q[1:0], g_q};
    dig = (t == 3'b000 || t == 3'b111) ? 36'd0 :
          (t == 3'b011) ? m_q << 1 :
          (t == 3'b100) ? -(m_q << 1) :
          (t == 3'b001 || t == 3'b010) ? m_q : -m_q;
    sum = u_q + dig;
    state_d = state_q;
    m_d = m_q;
    u_d = u_q;
    l_d = l_q;
    g_d = g_q;
    cnt_d = cnt_q;
    p_d = p_q;
    out_en_d = 1'b0;
    case (state_q)
      IDLE: if (in_en) begin
        m_d = {{4{a_signed & a[31]}}, a};
        l_d = {{2{b_signed & b[31]}}, b};
        u_d = '0;
        g_d = 1'b0;
        cnt_d = '0;
        state_d = ITER;
      end
      ITER: begin
        u_d = {{2{sum[35]}}, sum[35:2]};
        l_d = {sum[1:0], l_q[33:2]};
        g_d = l_q[1];
        cnt_d = cnt_q + 5'd1;
        state_d = (cnt_q == 5'd16) ? DONE : ITER;
      end
      DONE: begin
        p_d = {u_q[29:0], l_q};
        out_en_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q <= '0;
      u_q <= '0;
      l_q <= '0;
      g_q <= 1'b0;
      cnt_q <= '0;
      p_q <= '0;
      out_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q <= m_d;
      u_q <= u_d;
      l_q <= l_d;
      g_q <= g_d;
      cnt_q <= cnt_d;
      p_q <= p_d;
      out_en_q <= out_en_d;
    end
  end
  assign idle = (state_q == IDLE);
  assign out_en = out_en_q;
  assign p_hi = p_q[63:32];
  assign p_lo = p_q[31:0];
endmodule

// File: tb/tb_mul32.sv
// tb_mul32: self-checking bench for mul32 with vector table, corner sequences and random model compare
module tb_mul32;
  logic        clk = 1'b0, rst = 1'b1, in_en = 1'b0, a_signed = 1'b0, b_signed = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        idle, out_en;
  logic [31:0] p_hi, p_lo;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [31:0] a, b;
    logic        as, bs;
    logic [63:0] p;
  } vec_t;
  vec_t tv[8];
  mul32 dut (
    .clk(clk), .rst(rst), .in_en(in_en), .a(a), .b(b),
    .a_signed(a_signed), .b_signed(b_signed),
    .idle(idle), .out_en(out_en), .p_hi(p_hi), .p_lo(p_lo)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] ref_mul(logic [31:0] x, logic [31:0] y, logic xs, logic ys);
    longint sx, sy;
    sx = {{32{xs & x[31]}}, x};
    sy = {{32{ys & y[31]}}, y};
    return sx * sy;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run(input logic [31:0] ia, input logic [31:0] ib, input logic ias, input logic ibs,
                     output logic [63:0] p, output int lat);
    a = ia;
    b = ib;
    a_signed = ias;
    b_signed = ibs;
    in_en = 1'b1;
    @(posedge clk);
    #1;
    in_en = 1'b0;
    a = $urandom;
    b = $urandom;
    a_signed = 1'($urandom);
    b_signed = 1'($urandom);
    lat = 0;
    while (!out_en && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    p = {p_hi, p_lo};
  endtask
  initial begin
    logic [63:0] p, exp, held;
    int lat, pulses;
    tv[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE_00000001};
    tv[1] = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 64'h40000000_00000000};
    tv[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 64'h00000000_00000001};
    tv[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 64'hFFFFFFFF_00000001};
    tv[4] = '{32'h00000007, 32'hFFFFFFFE, 1'b1, 1'b0, 64'h00000006_FFFFFFF2};
    tv[5] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 64'h0B00EA4E_242D2080};
    tv[6] = '{32'h00000000, 32'h80000000, 1'b1, 1'b1, 64'h0};
    tv[7] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 64'hFFFFFFFF_80000000};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_idle", 64'(idle), 64'd1);
    chk("reset_out_en", 64'(out_en), 64'd0);
    chk("reset_p", {p_hi, p_lo}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      run(tv[i].a, tv[i].b, tv[i].as, tv[i].bs, p, lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd18);
      chk($sformatf("vec%0d_product", i), p, tv[i].p);
    end
    run(32'd3, 32'd5, 1'b0, 1'b0, p, lat);
    chk("b2b_latency", 64'(lat), 64'd18);
    chk("b2b_product", p, 64'd15);
    a = 32'h0000BEEF;
    b = 32'h00001234;
    a_signed = 1'b0;
    b_signed = 1'b0;
    in_en = 1'b1;
    @(posedge clk);
    #1;
    in_en = 1'b0;
    exp = 64'h0000BEEF * 64'h00001234;
    for (int k = 1; k <= 18; k++) begin
      if (k == 3 || k == 10) begin
        a = 32'hDEADBEEF;
        b = 32'hCAFEF00D;
        a_signed = 1'b1;
        b_signed = 1'b1;
        in_en = 1'b1;
      end else in_en = 1'b0;
      @(posedge clk);
      #1;
      if (k < 18) chk($sformatf("busy_idle_c%0d", k), 64'(idle), 64'd0);
    end
    in_en = 1'b0;
    chk("busy_out_en", 64'(out_en), 64'd1);
    chk("busy_idle_done", 64'(idle), 64'd1);
    chk("busy_product", {p_hi, p_lo}, exp);
    held = {p_hi, p_lo};
    repeat (3) @(posedge clk);
    #1;
    chk("hold_out_en", 64'(out_en), 64'd0);
    chk("hold_product", {p_hi, p_lo}, held);
    a = 32'h11111111;
    b = 32'h22222222;
    in_en = 1'b1;
    @(posedge clk);
    #1;
    in_en = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_idle", 64'(idle), 64'd1);
    chk("rst_mid_out_en", 64'(out_en), 64'd0);
    chk("rst_mid_p", {p_hi, p_lo}, 64'd0);
    pulses = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (out_en) pulses++;
    end
    chk("rst_mid_no_pulse", 64'(pulses), 64'd0);
    rst = 1'b1;
    in_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_en = 1'b0;
    pulses = 0;
    repeat (20) begin
      if (!idle) pulses++;
      @(posedge clk);
      #1;
      if (out_en) pulses++;
    end
    chk("rst_wins_dropped", 64'(pulses), 64'd0);
    run(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, p, lat);
    chk("after_rst_latency", 64'(lat), 64'd18);
    chk("after_rst_product", p, ref_mul(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0));
    for (int i = 0; i < 1200; i++) begin
      logic [31:0] ra, rb;
      logic ras, rbs;
      ra = (i % 17 == 0) ? 32'h80000000 : $urandom;
      rb = (i % 13 == 0) ? 32'hFFFFFFFF : $urandom;
      ras = i[0];
      rbs = i[1];
      run(ra, rb, ras, rbs, p, lat);
      if (lat != 18) chk($sformatf("rand%0d_latency", i), 64'(lat), 64'd18);
      chk($sformatf("rand%0d_%h_%h_%b%b", i, ra, rb, ras, rbs), p, ref_mul(ra, rb, ras, rbs));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
